// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: response owner and top-level state.
package sp_ram_arb_pkg;

  typedef enum logic {
    OWN_P0 = 1'b0,
    OWN_P1 = 1'b1
  } owner_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grants are combinational from req; the
// last-grant pointer moves only on a granted cycle.
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  owner_t last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && req_i[1]) begin
        gnt_o = (last_q == OWN_P1) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = OWN_P0;
    end else if (gnt_o[1]) begin
      last_d = OWN_P1;
    end
  end

  // Port 1 counts as most recent out of reset so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= OWN_P1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between the LSU (p0) and the debug bridge (p1).
// Build option SP_RAM_ARB_ZERO_INIT_EN: zero-fill the whole RAM after reset.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,

  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

  output logic                    busy_o
);

  localparam int unsigned BE_W      = DATA_WIDTH / 8;
  localparam int unsigned NUM_WORDS = RAM_SIZE / BE_W;
  localparam int unsigned BE_SHIFT  = $clog2(BE_W);

  logic                  run;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [1:0]            gnt;
  logic [1:0]            rvalid_q, rvalid_d;
  owner_t                owner_q, owner_d;

`ifdef SP_RAM_ARB_ZERO_INIT_EN
  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Zero-fill sequencer: one word per cycle, RUN follows the last word.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else if (state_q == INIT) begin
      if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
        state_q <= RUN;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign run       = (state_q == RUN);
  assign busy_o    = (state_q == INIT);
  assign fill_addr = ADDR_WIDTH'(cnt_q) << BE_SHIFT;
`else
  assign run       = 1'b1;
  assign busy_o    = 1'b0;
  assign fill_addr = '0;
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn_i (rstn_i),
    .en_i   (run),
    .req_i  ({p1_req_i, p0_req_i}),
    .gnt_o  (gnt)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  // RAM port mux: fill pattern in INIT, winner payload on grant, quiet otherwise.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    if (!run) begin
      ram_en_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_be_o   = '1;
      ram_addr_o = fill_addr;
    end else if (gnt[0]) begin
      ram_en_o    = 1'b1;
      ram_we_o    = p0_we_i;
      ram_addr_o  = p0_addr_i;
      ram_wdata_o = p0_wdata_i;
      ram_be_o    = p0_be_i;
    end else if (gnt[1]) begin
      ram_en_o    = 1'b1;
      ram_we_o    = p1_we_i;
      ram_addr_o  = p1_addr_i;
      ram_wdata_o = p1_wdata_i;
      ram_be_o    = p1_be_i;
    end
  end

  always_comb begin
    rvalid_d = gnt;
    owner_d  = owner_q;
    if (gnt[1]) begin
      owner_d = OWN_P1;
    end else if (gnt[0]) begin
      owner_d = OWN_P0;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q <= 2'b00;
      owner_q  <= OWN_P0;
    end else begin
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];

  // Read data is steered only to the owner of the response; the other port sees 0.
  assign p0_rdata_o = (rvalid_q[0] && (owner_q == OWN_P0)) ? ram_rdata_i : '0;
  assign p1_rdata_o = (rvalid_q[1] && (owner_q == OWN_P1)) ? ram_rdata_i : '0;

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Shares one single-port data RAM macro between two requesters. Port 0 is the core LSU and port 1 is the debug/AXI bridge. Each port uses a req/gnt/rvalid handshake, and conflicts are resolved round-robin, one access per cycle. The block sits directly in front of the SRAM wrapper and drives its enable, address, write-data, write-enable and byte-enable inputs. Optionally it zero-fills the whole RAM after reset, before granting any request.

## Interface
- RAM_SIZE, 32768, RAM size in bytes
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width on all ports
- DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8
- clk  in  1  single clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- pN_req_i  in  1  request, N ∈ {0,1}
- pN_gnt_o  out  1  grant, combinational from req and arbitration state
- pN_addr_i  in  ADDR_WIDTH  byte address
- pN_we_i  in  1  1 = write
- pN_be_i  in  DATA_WIDTH/8  byte enables
- pN_wdata_i  in  DATA_WIDTH  write data
- pN_rvalid_o  out  1  response valid, one cycle after grant
- pN_rdata_o  out  DATA_WIDTH  read data, meaningful while pN_rvalid_o is high
- ram_en_o  out  1  RAM access enable
- ram_addr_o  out  ADDR_WIDTH  RAM byte address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o
- busy_o  out  1  zero-fill in progress

## Operation
- **States:** INIT (zero-fill) and RUN.
- **RUN, one requester:** a single asserted req is granted in the same cycle.
- **RUN, both requesting:** grant the port not granted most recently.
  - The last-grant pointer updates only on a granted cycle.
  - Reset value: last = 1, so port 0 wins the first conflict.
- **RAM drive on grant:** ram_en_o = 1, and the winner's addr/we/be/wdata pass through combinationally.
- **RAM drive with no grant:** ram_en_o = 0, ram_we_o = 0, other RAM outputs = 0.
- **Response:**
  - On every grant, read or write, the block registers the owner id.
  - pN_rvalid_o is asserted for exactly one cycle, the cycle after the grant.
  - pN_rdata_o = ram_rdata_i when the port owns the response, otherwise 0.
  - A write also produces rvalid; its rdata is don't-care.
- **Requester rules:**
  - A requester keeps req and its payload stable until gnt.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- **Reset values:** all rvalid = 0, the owner register is cleared, last = 1, busy_o = 1 if zero-fill is compiled in (else 0), and the state is INIT (else RUN).
- **Reset mid-operation:** any outstanding rvalid is dropped. With zero-fill compiled in, fill restarts at word 0.

## Timing
- Grant-to-rvalid latency is 1 cycle, with full throughput of one access per cycle.
- gnt has a combinational path from req. rvalid and rdata have no combinational path from req.
- **INIT:**
  - A word counter runs 0 .. NUM_WORDS-1, with NUM_WORDS = RAM_SIZE/(DATA_WIDTH/8).
  - Each cycle: ram_en_o = 1, ram_we_o = 1, ram_be_o = all ones, ram_wdata_o = 0, ram_addr_o = counter × (DATA_WIDTH/8).
  - All gnt and rvalid outputs = 0.
- **INIT → RUN:** the transition follows the write of the last word, so INIT lasts exactly NUM_WORDS cycles.
  - busy_o falls in the same edge as the INIT → RUN transition.
  - The first grant is possible in the first RUN cycle.
- Requests asserted during INIT wait and are not lost, because the req-stable rule applies.

## Configuration
- Macro: SP_RAM_ARB_ZERO_INIT_EN.
- **Defined:** the INIT state, word counter and busy_o logic exist. The block resets into INIT.
- **Undefined:** there is no counter and no INIT. The block resets into RUN, and busy_o is tied to 0.

## Structure
- Package sp_ram_arb_pkg holds the owner_t enum (OWN_P0, OWN_P1) and the state_t enum (INIT, RUN).
- Sub-module rr_arb2 holds the two-input round-robin grant logic and the last-grant pointer.
- The top level holds the INIT counter, RAM mux, owner register and response routing.

## Test plan
- **Reset, macro defined, RAM_SIZE = 64:**
  - 16 cycles of writes to addresses 0x00..0x3C with be = 0xF and wdata = 0.
  - busy_o is low from cycle 17, and p0 is granted at that cycle.
- **p0 only:** write 0xDEADBEEF to 0x10, then read 0x10.
  - Grant is immediate.
  - rvalid follows 1 cycle later, with p0_rdata = 0xDEADBEEF.
- **p0 and p1 both request continuously for 4 cycles:**
  - Grants alternate p0, p1, p0, p1.
  - Each rvalid goes to the correct port, with no leakage to the other port's rdata.
- **Partial write:** be = 0x2 with wdata 0x0000AB00 to a zeroed word, then read it; expect 0x0000AB00.
- **Reset asserted mid-INIT at word 5:**
  - Fill restarts at word 0.
  - No gnt or rvalid appears during fill.
- **Macro undefined:**
  - busy_o = 0 from reset.
  - A p1 request in the first cycle after reset release is granted in that cycle.
